// File: rtl/outbuf_cell.sv
// -----------------------------------------------------------------------------
// outbuf_cell
//   Single-flit output buffer at a router output port. This is the transmit end
//   of the so/ro/dout link handshake. The crossbar loads a flit during the
//   internal phase. The cell offers that flit downstream during the external
//   phase, and it empties when downstream accepts the flit with ro. If the
//   crossbar enqueues while the cell is full, the flit is dropped and the
//   sticky ovf flag is raised.
//
//   Optional feature macro: OUTBUF_STATS_EN
//     Defining this macro adds the CNT_W parameter, the sent_cnt port and a
//     wrapping transfer counter.
//
// Ports
//   clk             in   1        rising-edge clock
//   reset           in   1        asynchronous active-low reset
//   phase_external  in   1        link phase, cell may transmit
//   phase_internal  in   1        core phase, crossbar may load
//   enq             in   1        crossbar enqueue strobe
//   d               in   DATA_W   flit from crossbar
//   full            out  1        cell holds a flit
//   so              out  1        send-out to downstream
//   ro              in   1        ready-out from downstream
//   dout            out  DATA_W   flit to downstream
//   ovf             out  1        sticky overflow flag
//   sent_cnt        out  CNT_W    transmitted flit count (OUTBUF_STATS_EN)
//
// State table
//   EMPTY | no flit held, a load is accepted in the internal phase
//   FULL  | flit held and offered in the external phase until ro
// -----------------------------------------------------------------------------
module outbuf_cell #(
    parameter int DATA_W = 64
`ifdef OUTBUF_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase_external,
    input  logic              phase_internal,
    input  logic              enq,
    input  logic [DATA_W-1:0] d,
    output logic              full,
    output logic              so,
    input  logic              ro,
    output logic [DATA_W-1:0] dout,
    output logic              ovf
`ifdef OUTBUF_STATS_EN
    ,
    output logic [CNT_W-1:0]  sent_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] storage_q;
    logic              ovf_q;
    logic              ext_ok;
    logic              int_ok;
    logic              load;
    logic              ovf_set;

    // If both phases are high, or both are low, the cell simply holds.
    assign ext_ok = phase_external & ~phase_internal;
    assign int_ok = phase_internal & ~phase_external;

    // so depends only on the state and the phase. There is no path from ro to so.
    assign full = (state_q == FULL);
    assign so   = full & ext_ok;
    assign dout = storage_q;
    assign ovf  = ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (int_ok && enq) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (so && ro) begin
                    state_d = EMPTY;
                end else if (int_ok && enq) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // On a transfer the storage keeps its value, so dout stays stable after the send.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            storage_q <= '0;
        end else if (load) begin
            storage_q <= d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef OUTBUF_STATS_EN
    logic             xfer;
    logic [CNT_W-1:0] cnt_q;

    assign xfer     = so & ro;
    assign sent_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_outbuf_cell.sv
module tb_outbuf_cell;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          phase_external = 1'b0;
    logic          phase_internal = 1'b0;
    logic          enq = 1'b0;
    logic [DW-1:0] d = '0;
    logic          ro = 1'b0;
    logic          full;
    logic          so;
    logic [DW-1:0] dout;
    logic          ovf;
`ifdef OUTBUF_STATS_EN
    logic [CW-1:0] sent_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

`ifdef OUTBUF_STATS_EN
    outbuf_cell #(.DATA_W(DW), .CNT_W(CW)) dut (
`else
    outbuf_cell #(.DATA_W(DW)) dut (
`endif
        .clk(clk), .reset(reset),
        .phase_external(phase_external), .phase_internal(phase_internal),
        .enq(enq), .d(d), .full(full), .so(so), .ro(ro), .dout(dout), .ovf(ovf)
`ifdef OUTBUF_STATS_EN
        , .sent_cnt(sent_cnt)
`endif
    );

    // Behavioural model. It tracks whether a flit is held, the flit value,
    // the sticky overflow flag and the number of transfers.
    logic          m_full;
    logic [DW-1:0] m_data;
    logic          m_ovf;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_full <= 1'b0;
            m_data <= '0;
            m_ovf  <= 1'b0;
            m_cnt  <= '0;
        end else begin
            if (m_full && phase_external && !phase_internal && ro) begin
                m_full <= 1'b0;
                m_cnt  <= m_cnt + 1'b1;
            end else if (phase_internal && !phase_external && enq) begin
                if (m_full) m_ovf <= 1'b1;
                else begin
                    m_full <= 1'b1;
                    m_data <= d;
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("m.full", {63'd0, full}, {63'd0, m_full});
        check("m.so", {63'd0, so}, {63'd0, m_full & phase_external & ~phase_internal});
        check("m.dout", dout, m_data);
        check("m.ovf", {63'd0, ovf}, {63'd0, m_ovf});
`ifdef OUTBUF_STATS_EN
        check("m.cnt", {60'd0, sent_cnt}, {60'd0, m_cnt});
`endif
    end

    // Each call applies one cycle of inputs shortly after a rising edge.
    task automatic drive(input logic pe, input logic pi, input logic e,
                         input logic [DW-1:0] dd, input logic r);
        @(posedge clk);
        #2;
        phase_external = pe;
        phase_internal = pi;
        enq = e;
        d = dd;
        ro = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [DW-1:0] dd);
        drive(1'b0, 1'b1, 1'b1, dd, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // T1: reset held with the external phase active and ro high.
        phase_external = 1'b1;
        ro = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        sample();
        check("t1.so", {63'd0, so}, 64'd0);
        check("t1.full", {63'd0, full}, 64'd0);
        check("t1.dout", dout, 64'd0);
        check("t1.ovf", {63'd0, ovf}, 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        sample();
        check("t1.so_rel", {63'd0, so}, 64'd0);

        // T2: load one flit, then send it.
        load(64'hDEADBEEF_F0F0A5A5);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        sample();
        check("t2.full", {63'd0, full}, 64'd1);
        check("t2.so", {63'd0, so}, 64'd1);
        check("t2.dout", dout, 64'hDEADBEEF_F0F0A5A5);
        idle();
        sample();
        check("t2.full_after", {63'd0, full}, 64'd0);
        check("t2.so_after", {63'd0, so}, 64'd0);
        check("t2.dout_kept", dout, 64'hDEADBEEF_F0F0A5A5);
`ifdef OUTBUF_STATS_EN
        check("t2.cnt", {60'd0, sent_cnt}, 64'd1);
`endif

        // T3: back-pressure from downstream.
        load(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
            sample();
            check("t3.so_stall", {63'd0, so}, 64'd1);
            check("t3.full_stall", {63'd0, full}, 64'd1);
            check("t3.dout_stall", dout, 64'h0123_4567_89AB_CDEF);
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        sample();
        check("t3.full_done", {63'd0, full}, 64'd0);
        check("t3.so_done", {63'd0, so}, 64'd0);

        // T4: enqueue while full sets ovf.
        load(64'h1);
        load(64'h2);
        idle();
        sample();
        check("t4.dout", dout, 64'h1);
        check("t4.ovf", {63'd0, ovf}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle();
        sample();
        check("t4.full", {63'd0, full}, 64'd0);
        check("t4.ovf_sticky", {63'd0, ovf}, 64'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        sample();
        check("t4.ovf_clr", {63'd0, ovf}, 64'd0);

        // T5: phase qualifiers.
        drive(1'b1, 1'b0, 1'b1, 64'h5, 1'b1);
        idle();
        sample();
        check("t5.noload_ext", {63'd0, full}, 64'd0);
        drive(1'b1, 1'b1, 1'b1, 64'h6, 1'b1);
        idle();
        sample();
        check("t5.noload_both", {63'd0, full}, 64'd0);
        load(64'h7);
        drive(1'b1, 1'b1, 1'b1, 64'h9, 1'b1);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        sample();
        check("t5.hold_full", {63'd0, full}, 64'd1);
        check("t5.so_both", {63'd0, so}, 64'd0);
        check("t5.ovf", {63'd0, ovf}, 64'd0);
        check("t5.dout", dout, 64'h7);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        sample();
        check("t5.hold_none", {63'd0, full}, 64'd1);

        // T6: reset asserted mid-flight while the flit is being offered.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        sample();
        check("t6.so_pre", {63'd0, so}, 64'd1);
        #1 reset = 1'b0;
        #1;
        check("t6.so_rst", {63'd0, so}, 64'd0);
        check("t6.full_rst", {63'd0, full}, 64'd0);
        check("t6.dout_rst", dout, 64'd0);
        ro = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        sample();
        check("t6.so_rel", {63'd0, so}, 64'd0);

`ifdef OUTBUF_STATS_EN
        for (int i = 0; i < 16; i++) begin
            load(64'(i + 100));
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            if (i == 14) begin
                idle();
                sample();
                check("t6.cnt15", {60'd0, sent_cnt}, 64'd15);
            end
        end
        idle();
        sample();
        check("t6.cnt_wrap", {60'd0, sent_cnt}, 64'd0);
`endif

        repeat (2) idle();
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
